yasac_mem_arbiter: RTL

Shared data-memory arbiter for the YASAC system. Grants three requesters (0: processor data unit, 1: program loader, 2: debug/monitor port) mutually exclusive access to one synchronous single-port data memory, using round-robin with an optional bounded lock for bursts. It sits between the requesters and the memory and performs one read or write per grant with a fixed 4-cycle transfer.

---
 rtl/yasac_mem_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/yasac_mem_arbiter.sv
// yasac_mem_arbiter: round-robin arbiter with a bounded lock that gives three requesters
// one fixed 4-cycle access each to a single-port synchronous data memory.
module yasac_mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [2:0]    REQ,
   input  logic [2:0]    LOCK,
   input  logic [2:0]    WE,
   input  logic [AW-1:0] ADDR0,
   input  logic [AW-1:0] ADDR1,
   input  logic [AW-1:0] ADDR2,
   input  logic [DW-1:0] WDATA0,
   input  logic [DW-1:0] WDATA1,
   input  logic [DW-1:0] WDATA2,
   output logic [2:0]    GNT,
   output logic [2:0]    ACK,
   output logic [DW-1:0] RDATA,
   output logic          BUSY,
   output logic          MEM_EN,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA
);
   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
   state_t        state_q, state_d;
   logic [1:0]    w_q, w_d, last_q, last_d, nxt1, nxt2, rr_w;
   logic [3:0]    hcnt_q, hcnt_d;
   logic          lock_q, lock_d, lock_hit, acc;
   logic [DW-1:0] rdata_q, rdata_d;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         w_q     <= 2'd0;
         last_q  <= 2'd2;
         hcnt_q  <= 4'd0;
         lock_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         last_q  <= last_d;
         hcnt_q  <= hcnt_d;
         lock_q  <= lock_d;
         rdata_q <= rdata_d;
      end
   end

   // lock_q remembers whether the last winner (still in w_q) asked to keep the grant
   always_comb begin
      nxt1     = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      nxt2     = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
      rr_w     = REQ[nxt1] ? nxt1 : REQ[nxt2] ? nxt2 : last_q;
      lock_hit = lock_q && REQ[w_q] && (hcnt_q < 4'(MAX_HOLD));
      state_d  = state_q;
      w_d      = w_q;
      last_d   = last_q;
      hcnt_d   = hcnt_q;
      lock_d   = lock_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: if (REQ != 3'b000) begin
            state_d = ACCESS;
            w_d     = lock_hit ? w_q : rr_w;
            last_d  = lock_hit ? last_q : rr_w;
            hcnt_d  = lock_hit ? hcnt_q + 4'd1 : 4'd0;
         end
         ACCESS: state_d = CAPTURE;
         CAPTURE: begin
            state_d = RESP;
            rdata_d = WE[w_q] ? rdata_q : MEM_RDATA;
         end
         default: begin
            state_d = IDLE;
            lock_d  = LOCK[w_q];
         end
      endcase
   end

   always_comb begin
      acc       = (state_q == ACCESS);
      BUSY      = (state_q != IDLE);
      GNT       = BUSY ? 3'b001 << w_q : 3'b000;
      ACK       = (state_q == RESP) ? 3'b001 << w_q : 3'b000;
      RDATA     = rdata_q;
      MEM_EN    = acc;
      MEM_WE    = acc & WE[w_q];
      MEM_ADDR  = !acc ? '0 : (w_q == 2'd0) ? ADDR0 : (w_q == 2'd1) ? ADDR1 : ADDR2;
      MEM_WDATA = !acc ? '0 : (w_q == 2'd0) ? WDATA0 : (w_q == 2'd1) ? WDATA1 : WDATA2;
   end
endmodule
